apb_fifo_slave: RTL and testbench

APB responder peripheral: a DEPTH-word FIFO mailbox that cores reach through the APB interconnect. It decodes PADDR[1:0] into four registers: DATA push/pop, STATUS, CTRL and PEEK. Transfers can be stretched by a configurable number of wait states. It sits on one slave port of the interconnect and consumes that port's PSEL bit, PENABLE, PADDR, PWRITE and PWDATA; it returns PRDATA and PREADY.

---
 rtl/apb_fifo_slave.sv | 152 +++++++++++++++
 tb/tb_apb_fifo_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_slave.sv
// APB responder exposing a DEPTH-word FIFO mailbox through DATA/STATUS/CTRL/PEEK registers.
// Transfers may be stretched by WAIT_CYCLES wait states before completion.
module apb_fifo_slave #(
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic                  irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StIdle, StAccess} state_t;

    state_t                state;
    logic [3:0]            wcnt;
    logic [1:0]            addr;
    logic                  write;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  ovf;
    logic                  udf;

    logic                  ready;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_flush;
    logic                  do_clear;
    logic                  set_ovf;
    logic                  set_udf;
    logic [DATA_WIDTH-1:0] status;
    logic                  unused;

    // Only the register-select bits are decoded.
    assign unused = ^S_PADDR[BUS_WIDTH-1:2];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign irq   = !empty;

    assign ready = (state == StAccess) && S_PSELx && S_PENABLE && (wcnt == 4'd0);

    assign do_push  = ready && write && (addr == 2'd0) && !full;
    assign set_ovf  = ready && write && (addr == 2'd0) && full;
    assign do_pop   = ready && !write && (addr == 2'd0) && !empty;
    assign set_udf  = ready && !write && (addr == 2'd0) && empty;
    assign do_flush = ready && write && (addr == 2'd2) && S_PWDATA[0];
    assign do_clear = ready && write && (addr == 2'd2) && S_PWDATA[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            wcnt  <= 4'd0;
            addr  <= 2'd0;
            write <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (S_PSELx && !S_PENABLE) begin
                        addr  <= S_PADDR[1:0];
                        write <= S_PWRITE;
                        wcnt  <= 4'(WAIT_CYCLES);
                        state <= StAccess;
                    end
                end
                StAccess: begin
                    if (!S_PSELx) begin
                        state <= StIdle;
                    end else if (S_PENABLE) begin
                        if (wcnt != 4'd0) begin
                            wcnt <= wcnt - 4'd1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (do_flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else if (do_push) begin
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end else if (do_pop) begin
                rptr  <= rptr + 1'b1;
                count <= count - 1'b1;
            end
            if (set_ovf) ovf <= 1'b1;
            if (set_udf) udf <= 1'b1;
            if (do_clear) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
        end
    end

    // Storage is not reset; flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= S_PWDATA;
    end

    always_comb begin
        status         = '0;
        status[0]      = empty;
        status[1]      = full;
        status[2]      = ovf;
        status[3]      = udf;
        status[8 +: CW] = count;
    end

    always_comb begin
        S_PRDATA = '0;
        if (ready && !write) begin
            case (addr)
                2'd0, 2'd3: if (!empty) S_PRDATA = mem[rptr];
                2'd1:       S_PRDATA = status;
                default:    S_PRDATA = '0;
            endcase
        end
    end

    assign S_PREADY = ready;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: two instances (0 and 3 wait states) checked every cycle against
// a queue-based mailbox model, plus directed reads with literal expectations.
module tb_apb_fifo_slave;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [15:0] paddr;
    logic        pwrite;
    logic        penable;
    logic [15:0] pwdata;
    logic [1:0]  psel;
    logic [1:0]  rdy;
    logic [1:0]  irq;
    logic [15:0] rdata0;
    logic [15:0] rdata1;

    logic [1:0]  exp_ready;
    logic [15:0] exp_rdata [2];
    logic        started;

    int vectors;
    int miscompares;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [1:0]  ovf_m;
    logic [1:0]  udf_m;

    apb_fifo_slave #(
        .BUS_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel[0]),
        .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(rdata0), .S_PREADY(rdy[0]),
        .irq(irq[0])
    );

    apb_fifo_slave #(
        .BUS_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(3)
    ) dut1 (
        .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel[1]),
        .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(rdata1), .S_PREADY(rdy[1]),
        .irq(irq[1])
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] mhead(input int k);
        if (msize(k) == 0) return 16'h0000;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [15:0] mstatus(input int k);
        int n;
        logic [15:0] s;
        n = msize(k);
        s = {8'(n), 4'b0000, udf_m[k], ovf_m[k], (n == DEPTH), (n == 0)};
        return s;
    endfunction

    function automatic logic [15:0] model_rdata(input int k, input bit wr, input logic [1:0] a);
        if (wr) return 16'h0000;
        case (a)
            2'd0, 2'd3: return mhead(k);
            2'd1:       return mstatus(k);
            default:    return 16'h0000;
        endcase
    endfunction

    function automatic void model_commit(input int k, input bit wr, input logic [1:0] a,
                                         input logic [15:0] wd);
        if (wr && a == 2'd0) begin
            if (msize(k) == DEPTH) ovf_m[k] = 1'b1;
            else if (k == 0) q0.push_back(wd);
            else q1.push_back(wd);
        end else if (wr && a == 2'd2) begin
            if (wd[1]) begin
                ovf_m[k] = 1'b0;
                udf_m[k] = 1'b0;
            end
            if (wd[0]) begin
                if (k == 0) q0.delete();
                else q1.delete();
            end
        end else if (!wr && a == 2'd0) begin
            if (msize(k) == 0) udf_m[k] = 1'b1;
            else if (k == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        ovf_m = 2'b00;
        udf_m = 2'b00;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("pready0", 32'(rdy[0]), 32'(exp_ready[0]));
            chk("prdata0", 32'(rdata0), 32'(exp_rdata[0]));
            chk("irq0", 32'(irq[0]), 32'(msize(0) != 0));
            chk("pready1", 32'(rdy[1]), 32'(exp_ready[1]));
            chk("prdata1", 32'(rdata1), 32'(exp_rdata[1]));
            chk("irq1", 32'(irq[1]), 32'(msize(1) != 0));
        end
    end

    // Called at posedge+1; returns at posedge+1. abort_at >= 0 drops PSEL in that wait cycle.
    task automatic xfer(input int k, input bit wr, input logic [1:0] a, input logic [15:0] wd,
                        input int abort_at, output logic [15:0] rd, output int waits);
        int w;
        w = (k == 0) ? 0 : 3;
        rd = 16'h0000;
        waits = 0;
        paddr = {14'($urandom), a};
        pwrite = wr;
        pwdata = wd;
        penable = 1'b0;
        psel[k] = 1'b1;
        exp_ready[k] = 1'b0;
        exp_rdata[k] = 16'h0000;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i == abort_at) begin
                psel[k] = 1'b0;
                penable = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (rdy[k] == 1'b0) waits++;
            @(posedge clk); #1;
        end
        exp_ready[k] = 1'b1;
        exp_rdata[k] = model_rdata(k, wr, a);
        @(negedge clk);
        rd = (k == 0) ? rdata0 : rdata1;
        @(posedge clk);
        model_commit(k, wr, a, wd);
        #1;
        psel[k] = 1'b0;
        penable = 1'b0;
        exp_ready[k] = 1'b0;
        exp_rdata[k] = 16'h0000;
    endtask

    task automatic wr_reg(input int k, input logic [1:0] a, input logic [15:0] d);
        logic [15:0] rd;
        int w;
        xfer(k, 1'b1, a, d, -1, rd, w);
    endtask

    task automatic rd_chk(input int k, input logic [1:0] a, input logic [15:0] exp,
                          input string name);
        logic [15:0] rd;
        int w;
        xfer(k, 1'b0, a, 16'h0000, -1, rd, w);
        chk(name, 32'(rd), 32'(exp));
    endtask

    initial begin
        logic [15:0] rd;
        int w;
        vectors = 0;
        miscompares = 0;
        started = 1'b0;
        clk = 1'b0;
        reset = 1'b1;
        psel = 2'b00;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 16'h0000;
        pwdata = 16'h0000;
        exp_ready = 2'b00;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pready", 32'(rdy), 32'h0);
        chk("rst_prdata", 32'({rdata1, rdata0}), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;
        rd_chk(0, 2'd1, 16'h0001, "rst_status");

        wr_reg(0, 2'd0, 16'h1234);
        wr_reg(0, 2'd0, 16'hBEEF);
        chk("irq_after_push", 32'(irq[0]), 32'h1);
        rd_chk(0, 2'd0, 16'h1234, "pop1");
        rd_chk(0, 2'd0, 16'hBEEF, "pop2");
        chk("irq_after_pop2", 32'(irq[0]), 32'h0);
        rd_chk(0, 2'd1, 16'h0001, "status_drained");

        for (int i = 0; i < 9; i++) wr_reg(0, 2'd0, 16'(i));
        rd_chk(0, 2'd1, 16'h0806, "status_full_ovf");
        for (int i = 0; i < 8; i++) rd_chk(0, 2'd0, 16'(i), "pop_fill");
        wr_reg(0, 2'd0, 16'h00AA);
        rd_chk(0, 2'd0, 16'h00AA, "wrap_pop");

        rd_chk(0, 2'd0, 16'h0000, "pop_empty");
        rd_chk(0, 2'd1, 16'h000D, "status_udf_ovf");
        wr_reg(0, 2'd2, 16'h0002);
        rd_chk(0, 2'd1, 16'h0001, "status_cleared");
        rd_chk(0, 2'd3, 16'h0000, "peek_empty");
        rd_chk(0, 2'd1, 16'h0001, "peek_no_udf");
        wr_reg(0, 2'd1, 16'hFFFF);
        rd_chk(0, 2'd2, 16'h0000, "ctrl_reads_zero");

        xfer(1, 1'b1, 2'd0, 16'h5555, -1, rd, w);
        chk("wait_write", 32'(w), 32'd3);
        xfer(1, 1'b0, 2'd0, 16'h0000, -1, rd, w);
        chk("wait_read", 32'(w), 32'd3);
        chk("wait_read_data", 32'(rd), 32'h5555);
        rd_chk(1, 2'd1, 16'h0001, "status_w3");

        wr_reg(1, 2'd0, 16'h7777);
        xfer(1, 1'b0, 2'd0, 16'h0000, 2, rd, w);
        rd_chk(1, 2'd1, 16'h0100, "abort_count");
        rd_chk(1, 2'd3, 16'h7777, "abort_peek");

        wr_reg(0, 2'd0, 16'h0011);
        wr_reg(0, 2'd0, 16'h0022);
        wr_reg(0, 2'd0, 16'h0033);
        rd_chk(0, 2'd3, 16'h0011, "peek_head");
        rd_chk(0, 2'd1, 16'h0300, "peek_count");
        wr_reg(0, 2'd2, 16'h0001);
        chk("irq_after_flush", 32'(irq[0]), 32'h0);
        rd_chk(0, 2'd1, 16'h0001, "flush_status");

        wr_reg(0, 2'd0, 16'h4444);
        psel[1] = 1'b1;
        pwrite = 1'b1;
        paddr = 16'h0000;
        pwdata = 16'h9999;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        chk("midrst_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;
        rd_chk(1, 2'd1, 16'h0001, "midrst_status1");
        rd_chk(0, 2'd1, 16'h0001, "midrst_status0");
        rd_chk(1, 2'd3, 16'h0000, "midrst_peek1");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
